// File: rtl/mr_ldst_pipe.sv
// mr_ldst_pipe: pipelined load/store unit driving a pipelined Wishbone B4 master with an in-order metadata FIFO.
// Optional MR_LDST_MISALIGN_TRAP_EN: misaligned H/W requests fault instead of being address-masked.
module mr_ldst_pipe #(
  parameter int XLEN            = 32,
  parameter int REGSEL_BITS     = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             ex_op_i,
  input  logic [1:0]             ex_size_i,
  input  logic                   ex_signed_i,
  input  logic [XLEN-1:0]        ex_addr_i,
  input  logic [XLEN-1:0]        ex_payload_i,
  input  logic [REGSEL_BITS-1:0] ex_dst_reg_i,
  input  logic                   ex_valid_i,
  output logic                   ex_ready_o,
  output logic                   wb_write_o,
  output logic [XLEN-1:0]        wb_payload_o,
  output logic [REGSEL_BITS-1:0] wb_dst_reg_o,
  output logic                   fault_o,
  output logic [XLEN-1:0]        fault_addr_o,
  output logic [XLEN-3:0]        addr_o,
  output logic                   we_o,
  output logic [XLEN/8-1:0]      sel_o,
  output logic [XLEN-1:0]        dat_o,
  output logic                   stb_o,
  output logic                   cyc_o,
  input  logic                   ack_i,
  input  logic                   err_i,
  input  logic                   stall_i,
  input  logic [XLEN-1:0]        dat_i
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  typedef struct packed {
    logic [XLEN-1:0]        addr;
    logic [1:0]             size;
    logic                   sgn;
    logic [REGSEL_BITS-1:0] dst;
    logic [LB-1:0]          lane;
    logic                   ld;
  } meta_t;
  meta_t                  fifo_q [MAX_OUTSTANDING];
  meta_t                  head, push_meta;
  logic [PW-1:0]          wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   stb_q, cyc_q, we_q, wb_write_q, fault_q;
  logic                   stb_d, cyc_d, wb_write_d, fault_d;
  logic [NB-1:0]          sel_q, sel_d;
  logic [XLEN-1:0]        dat_q, dat_d, wb_payload_q, fault_addr_q, sh, ld_val;
  logic [XLEN-3:0]        addr_q;
  logic [REGSEL_BITS-1:0] wb_dst_q;
  logic [LB-1:0]          lane;
  logic                   is_mem, sz_b, sz_h, mis, accept, push, pop, err_v, none_acc;
  assign is_mem = (ex_op_i == 2'd1) || (ex_op_i == 2'd2);
  assign sz_b   = ex_size_i == 2'd0;
  assign sz_h   = ex_size_i == 2'd1;
  assign lane   = sz_b ? ex_addr_i[LB-1:0] : sz_h ? {ex_addr_i[LB-1:1], 1'b0} : '0;
`ifdef MR_LDST_MISALIGN_TRAP_EN
  // Misaligned exactly when size masking would have changed the lane.
  assign mis = is_mem && (ex_addr_i[LB-1:0] != lane);
`else
  assign mis = 1'b0;
`endif
  // NONE ops wait for an idle bus so their writeback cannot overtake pending loads.
  assign ex_ready_o = !reset && (!stb_q || !stall_i) && (count_q < CW'(MAX_OUTSTANDING))
                      && (is_mem || (count_q == '0 && !stb_q));
  assign accept    = ex_valid_i && ex_ready_o;
  assign push      = accept && is_mem && !mis;
  assign none_acc  = accept && !is_mem;
  assign err_v     = err_i && (count_q != '0);
  assign pop       = ack_i && (count_q != '0) && !err_v;
  assign head      = fifo_q[rd_q];
  assign push_meta = {ex_addr_i, ex_size_i, ex_signed_i, ex_dst_reg_i, lane, ex_op_i == 2'd1};
  always_comb begin
    sel_d      = sz_b ? NB'(1) << lane : sz_h ? NB'(3) << lane : '1;
    dat_d      = sz_b ? {NB{ex_payload_i[7:0]}} : sz_h ? {(NB/2){ex_payload_i[15:0]}} : ex_payload_i;
    sh         = dat_i >> {head.lane, 3'b000};
    ld_val     = head.size == 2'd0 ? {{(XLEN-8){head.sgn & sh[7]}}, sh[7:0]}
               : head.size == 2'd1 ? {{(XLEN-16){head.sgn & sh[15]}}, sh[15:0]} : sh;
    count_d    = err_v ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d       = err_v ? '0 : wr_q + PW'(push);
    rd_d       = err_v ? '0 : rd_q + PW'(pop);
    stb_d      = !err_v && (push || (stb_q && stall_i));
    cyc_d      = !err_v && (count_d != '0);
    wb_write_d = !err_v && ((pop && head.ld) || none_acc);
    fault_d    = err_v || (accept && mis);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wb_write_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      wb_write_q <= wb_write_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      if (push) begin
        we_q  <= ex_op_i == 2'd2;
        sel_q <= sel_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q       <= ex_addr_i[XLEN-1:2];
      dat_q        <= dat_d;
      fifo_q[wr_q] <= push_meta;
    end
    wb_payload_q <= none_acc ? ex_addr_i : ld_val;
    wb_dst_q     <= none_acc ? ex_dst_reg_i : head.dst;
    fault_addr_q <= err_v ? head.addr : ex_addr_i;
  end
  assign stb_o        = stb_q;
  assign cyc_o        = cyc_q;
  assign we_o         = we_q;
  assign sel_o        = sel_q;
  assign dat_o        = dat_q;
  assign addr_o       = addr_q;
  assign wb_write_o   = wb_write_q;
  assign wb_payload_o = wb_payload_q;
  assign wb_dst_reg_o = wb_dst_q;
  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;
endmodule
